// File: rtl/regfile_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : regfile_ctrl
// Function : Register-file write-port / rs1 owner: post-reset clear sweep,
//            core writeback pass-through and host debug read/write access.
// Revision : 1.0  initial release
// ============================================================================
module regfile_ctrl #(
    parameter logic [31:0] SP_INIT  = 32'h0000_8000,
    parameter int unsigned MAX_WAIT = 3
) (
    input  logic        CLK,
    input  logic        RST_X,
    input  logic        core_we,
    input  logic [4:0]  core_rd,
    input  logic [31:0] core_wd,
    input  logic [4:0]  core_rs1,
    output logic        core_stall,
    output logic        init_done,
    input  logic        dbg_req,
    input  logic        dbg_wr,
    input  logic [4:0]  dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_ack,
    output logic [31:0] dbg_rdata,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_wd,
    output logic [4:0]  rf_rs1,
    input  logic [31:0] rf_rrs1
);

    localparam int unsigned       c_WAIT_W    = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(MAX_WAIT - 1);

    localparam logic [1:0] c_INIT = 2'd0;
    localparam logic [1:0] c_IDLE = 2'd1;
    localparam logic [1:0] c_DBG  = 2'd2;
    localparam logic [1:0] c_ACK  = 2'd3;

    logic [1:0]          r_state;
    logic [4:0]          r_idx;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic                r_init_done;
    logic [31:0]         r_dbg_rdata;
    logic                w_we;

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_state     <= c_INIT;
            r_idx       <= 5'd1;
            r_wait_cnt  <= '0;
            r_init_done <= 1'b0;
            r_dbg_rdata <= 32'd0;
        end else begin
            case (r_state)
                c_INIT: begin
                    r_idx <= r_idx + 5'd1;
                    if (r_idx == 5'd31) begin
                        r_state     <= c_IDLE;
                        r_init_done <= 1'b1;
                    end
                end
                c_IDLE: begin
                    if (!dbg_req) begin
                        r_wait_cnt <= '0;
                    end else if (!core_we || (r_wait_cnt == c_WAIT_LAST)) begin
                        // Forced entry after MAX_WAIT lost cycles bounds debug latency.
                        r_state    <= c_DBG;
                        r_wait_cnt <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                c_DBG: begin
                    r_dbg_rdata <= rf_rrs1;
                    r_state     <= c_ACK;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_we   = 1'b0;
        rf_rd  = core_rd;
        rf_wd  = core_wd;
        rf_rs1 = core_rs1;
        case (r_state)
            c_INIT: begin
                w_we  = 1'b1;
                rf_rd = r_idx;
                rf_wd = (r_idx == 5'd2) ? SP_INIT : 32'd0;
            end
            c_DBG: begin
                w_we   = dbg_wr && (dbg_addr != 5'd0);
                rf_rd  = dbg_addr;
                rf_wd  = dbg_wdata;
                rf_rs1 = dbg_addr;
            end
            default: begin
                w_we = core_we;
            end
        endcase
    end

    // Write enable is gated by the raw reset so nothing commits while held in reset.
    assign rf_we      = w_we & RST_X;
    assign core_stall = (r_state == c_INIT) || (r_state == c_DBG);
    assign dbg_ack    = (r_state == c_ACK);
    assign init_done  = r_init_done;
    assign dbg_rdata  = r_dbg_rdata;

endmodule
`default_nettype wire

// File: tb/tb_regfile_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_ctrl
// Function : Directed self-checking bench for regfile_ctrl with a behavioural
//            32x32 register file attached to the write and rs1 ports.
// Revision : 1.0  initial release
// ============================================================================
module tb_regfile_ctrl;

    logic        CLK = 1'b0;
    logic        RST_X;
    logic        core_we;
    logic [4:0]  core_rd;
    logic [31:0] core_wd;
    logic [4:0]  core_rs1;
    logic        core_stall;
    logic        init_done;
    logic        dbg_req;
    logic        dbg_wr;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wd;
    logic [4:0]  rf_rs1;
    logic [31:0] rf_rrs1;

    int checks = 0;
    int errors = 0;

    regfile_ctrl #(
        .SP_INIT  (32'h0000_8000),
        .MAX_WAIT (3)
    ) dut (
        .CLK        (CLK),
        .RST_X      (RST_X),
        .core_we    (core_we),
        .core_rd    (core_rd),
        .core_wd    (core_wd),
        .core_rs1   (core_rs1),
        .core_stall (core_stall),
        .init_done  (init_done),
        .dbg_req    (dbg_req),
        .dbg_wr     (dbg_wr),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_ack    (dbg_ack),
        .dbg_rdata  (dbg_rdata),
        .rf_we      (rf_we),
        .rf_rd      (rf_rd),
        .rf_wd      (rf_wd),
        .rf_rs1     (rf_rs1),
        .rf_rrs1    (rf_rrs1)
    );

    always #5 CLK = ~CLK;

    // Register file: write sampled at posedge, committed at the following negedge.
    logic [31:0] regs [32];
    logic        p_we = 1'b0;
    logic [4:0]  p_rd = 5'd0;
    logic [31:0] p_wd = 32'd0;

    initial for (int i = 0; i < 32; i++) regs[i] = 32'd0;

    always @(posedge CLK) begin
        p_we <= rf_we;
        p_rd <= rf_rd;
        p_wd <= rf_wd;
    end
    always @(negedge CLK) begin
        if (p_we && (p_rd != 5'd0)) regs[p_rd] <= p_wd;
    end
    assign rf_rrs1 = (rf_rs1 == 5'd0) ? 32'd0 : regs[rf_rs1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Uncontended debug access starting from an IDLE cycle with core_we=0.
    task automatic dbg_access(input logic wr, input logic [4:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp_rdata,
                              input string tag);
        dbg_req = 1'b1; dbg_wr = wr; dbg_addr = addr; dbg_wdata = wdata;
        #1;
        chk({tag, "_req_ack"}, {31'd0, dbg_ack}, 32'd0);
        chk({tag, "_req_stall"}, {31'd0, core_stall}, 32'd0);
        tick();
        chk({tag, "_dbg_stall"}, {31'd0, core_stall}, 32'd1);
        chk({tag, "_dbg_we"}, {31'd0, rf_we}, {31'd0, wr && (addr != 5'd0)});
        chk({tag, "_dbg_rs1"}, {27'd0, rf_rs1}, {27'd0, addr});
        if (wr && (addr != 5'd0)) begin
            chk({tag, "_dbg_rd"}, {27'd0, rf_rd}, {27'd0, addr});
            chk({tag, "_dbg_wd"}, rf_wd, wdata);
        end
        tick();
        chk({tag, "_ack"}, {31'd0, dbg_ack}, 32'd1);
        chk({tag, "_rdata"}, dbg_rdata, exp_rdata);
        dbg_req = 1'b0;
        tick();
        chk({tag, "_ack_drop"}, {31'd0, dbg_ack}, 32'd0);
        chk({tag, "_rdata_hold"}, dbg_rdata, exp_rdata);
    endtask

    initial begin
        RST_X = 1'b0; core_we = 1'b0; core_rd = 5'd0; core_wd = 32'd0; core_rs1 = 5'd3;
        dbg_req = 1'b0; dbg_wr = 1'b0; dbg_addr = 5'd0; dbg_wdata = 32'd0;

        // Reset state
        tick(); tick();
        chk("rst_stall", {31'd0, core_stall}, 32'd1);
        chk("rst_init_done", {31'd0, init_done}, 32'd0);
        chk("rst_ack", {31'd0, dbg_ack}, 32'd0);
        chk("rst_rdata", dbg_rdata, 32'd0);
        chk("rst_we", {31'd0, rf_we}, 32'd0);

        // Init sweep x1..x31, SP at x2
        RST_X = 1'b1;
        #1;
        for (int i = 1; i <= 31; i++) begin
            chk("sweep_we", {31'd0, rf_we}, 32'd1);
            chk("sweep_rd", {27'd0, rf_rd}, i);
            chk("sweep_wd", rf_wd, (i == 2) ? 32'h0000_8000 : 32'd0);
            chk("sweep_stall", {31'd0, core_stall}, 32'd1);
            chk("sweep_done_low", {31'd0, init_done}, 32'd0);
            chk("sweep_rs1", {27'd0, rf_rs1}, 32'd3);
            tick();
        end
        chk("sweep_done", {31'd0, init_done}, 32'd1);
        chk("idle_stall", {31'd0, core_stall}, 32'd0);
        chk("idle_we", {31'd0, rf_we}, 32'd0);

        // Debug write then read of x5
        dbg_access(1'b1, 5'd5, 32'hDEAD_BEEF, 32'd0, "wr_x5");
        dbg_access(1'b0, 5'd5, 32'd0, 32'hDEAD_BEEF, "rd_x5");

        // Debug read under continuous core writes: forced in after 3 lost cycles
        dbg_req = 1'b1; dbg_wr = 1'b0; dbg_addr = 5'd2;
        core_we = 1'b1; core_rd = 5'd10;
        for (int i = 1; i <= 3; i++) begin
            core_wd = 32'h100 + i;
            #1;
            chk("conf_pass_we", {31'd0, rf_we}, 32'd1);
            chk("conf_pass_rd", {27'd0, rf_rd}, 32'd10);
            chk("conf_pass_wd", rf_wd, 32'h100 + i);
            chk("conf_pass_stall", {31'd0, core_stall}, 32'd0);
            tick();
        end
        core_wd = 32'h104;
        #1;
        chk("conf_dbg_stall", {31'd0, core_stall}, 32'd1);
        chk("conf_dbg_we", {31'd0, rf_we}, 32'd0);
        chk("conf_dbg_rs1", {27'd0, rf_rs1}, 32'd2);
        chk("conf_dbg_ack", {31'd0, dbg_ack}, 32'd0);
        tick();
        chk("conf_ack", {31'd0, dbg_ack}, 32'd1);
        chk("conf_rdata", dbg_rdata, 32'h0000_8000);
        chk("conf_ack_we", {31'd0, rf_we}, 32'd1);
        chk("conf_ack_wd", rf_wd, 32'h104);
        chk("conf_ack_stall", {31'd0, core_stall}, 32'd0);
        dbg_req = 1'b0;
        tick();
        core_we = 1'b0;
        tick();
        dbg_access(1'b0, 5'd10, 32'd0, 32'h104, "rd_x10");

        // Write to x0 is acknowledged but discarded
        dbg_access(1'b1, 5'd0, 32'h1234, 32'd0, "wr_x0");
        dbg_access(1'b0, 5'd0, 32'd0, 32'd0, "rd_x0");

        // Reset during DBG: no ack, pending write dropped
        dbg_access(1'b0, 5'd5, 32'd0, 32'hDEAD_BEEF, "rd_x5b");
        dbg_req = 1'b1; dbg_wr = 1'b1; dbg_addr = 5'd9; dbg_wdata = 32'h55;
        tick();
        chk("pre_rst_dbg_stall", {31'd0, core_stall}, 32'd1);
        RST_X = 1'b0;
        #1;
        chk("dbgrst_we", {31'd0, rf_we}, 32'd0);
        chk("dbgrst_done", {31'd0, init_done}, 32'd0);
        chk("dbgrst_ack", {31'd0, dbg_ack}, 32'd0);
        chk("dbgrst_rdata", dbg_rdata, 32'd0);
        tick();
        chk("dbgrst_ack2", {31'd0, dbg_ack}, 32'd0);
        RST_X = 1'b1;
        #1;
        // dbg_req still high: ignored during the sweep
        for (int i = 1; i <= 17; i++) begin
            chk("sweep2_rd", {27'd0, rf_rd}, i);
            chk("sweep2_ack", {31'd0, dbg_ack}, 32'd0);
            if (i == 4) dbg_req = 1'b0;
            if (i < 17) tick();
        end
        RST_X = 1'b0;
        #1;
        chk("sweeprst_we", {31'd0, rf_we}, 32'd0);
        chk("sweeprst_done", {31'd0, init_done}, 32'd0);
        tick();
        RST_X = 1'b1;
        #1;
        chk("sweep3_rd1", {27'd0, rf_rd}, 32'd1);
        chk("sweep3_we1", {31'd0, rf_we}, 32'd1);
        tick();
        chk("sweep3_rd2", {27'd0, rf_rd}, 32'd2);
        chk("sweep3_wd2", rf_wd, 32'h0000_8000);
        for (int i = 0; i < 30; i++) tick();
        chk("sweep3_done", {31'd0, init_done}, 32'd1);
        dbg_access(1'b0, 5'd9, 32'd0, 32'd0, "rd_x9");
        dbg_access(1'b0, 5'd5, 32'd0, 32'd0, "rd_x5_cleared");

        // Debug write returns the pre-write value
        dbg_access(1'b1, 5'd7, 32'h11, 32'd0, "wr_x7_a");
        dbg_access(1'b1, 5'd7, 32'hA5, 32'h11, "wr_x7_b");
        dbg_access(1'b0, 5'd7, 32'd0, 32'hA5, "rd_x7");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
